// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through FIFO.
// Framing errors pulse frame_err; bytes arriving at a full FIFO set the sticky overrun flag.
module uart_rx_fifo #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rxd,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   clr_overrun
);
  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DW  = $clog2(DIV) + 1;
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic [1:0]    rst_q;
  logic          rst_n;
  logic [1:0]    sync_q;
  logic          rxd_s;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          last, push;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic [AW:0]   wptr_q, rptr_q;
  logic [7:0]    mem_q [DEPTH];
  logic          pop, full, wr;

  // Reset asserts immediately but is released on a clock edge so all state leaves reset together
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];

  assign rxd_s = sync_q[1];
  assign tick  = div_q == DW'(DIV - 1);
  assign div_d = tick ? '0 : div_q + DW'(1);
  assign last  = tick && (cnt_q == ((state_q == START) ? 4'd7 : 4'd15));

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? (last ? 4'd0 : cnt_q + 4'd1) : cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (!rxd_s) begin
        state_d = START;
        cnt_d   = 4'd0;
      end
      START: if (last) begin
        state_d = rxd_s ? IDLE : DATA;
        bit_d   = 3'd0;
      end
      DATA: if (last) begin
        sh_d    = {rxd_s, sh_q[7:1]};
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (last) begin
        state_d = rxd_s ? IDLE : BREAK;
        push    = rxd_s;
        ferr_d  = !rxd_s;
      end
      BREAK: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign level    = wptr_q - rptr_q;
  assign rx_valid = level != '0;
  assign rx_data  = mem_q[rptr_q[AW-1:0]];
  assign pop      = rx_valid && rx_ready;
  assign full     = level == (AW + 1)'(DEPTH);
  assign wr       = push && (!full || pop);
  assign ovr_d    = (push && full && !pop) || (ovr_q && !clr_overrun);

  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= 2'b11;
      div_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      div_q   <= div_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end

  // Storage is reset so rx_data reads 0 rather than X before the first byte lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr) begin
        mem_q[wptr_q[AW-1:0]] <= sh_q;
        wptr_q <= wptr_q + (AW + 1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (AW + 1)'(1);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo, run at a fast baud rate (DIV=4, 64 clk/bit)
// so the multi-frame FIFO scenarios stay short.
module tb_uart_rx_fifo;
  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 781250;
  localparam int DEPTH  = 16;
  localparam int DIV    = 4;
  localparam int BIT    = 16 * DIV;

  typedef struct {
    logic [7:0] data;
    logic       stop;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] level;
  logic       frame_err;
  logic       overrun;

  int total = 0, bad = 0, cyc = 0;
  int npop = 0, ferr_hi = 0, ferr_pulses = 0;
  logic ferr_prev = 1'b0;
  logic [7:0] last_pop = 8'h00;
  vec_t vec [6];

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .level(level), .frame_err(frame_err), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        npop++;
        last_pop = rx_data;
      end
      if (frame_err) ferr_hi++;
      if (frame_err && !ferr_prev) ferr_pulses++;
    end
    ferr_prev = frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int stop_len);
    rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BIT);
    end
    rxd = stop;
    idle(BIT * stop_len);
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    int p0, h0, c0, c1, lat, t;
    logic [7:0] b;
    vec[0] = '{8'hA5, 1'b1};
    vec[1] = '{8'h00, 1'b1};
    vec[2] = '{8'hFF, 1'b1};
    vec[3] = '{8'h3C, 1'b0};
    vec[4] = '{8'h5A, 1'b1};
    vec[5] = '{8'h81, 1'b1};

    #3 reset_n = 1'b0;
    idle(3);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    reset_n = 1'b1;
    idle(2 * BIT);

    for (int i = 0; i < 6; i++) begin
      p0 = ferr_pulses;
      h0 = ferr_hi;
      send(vec[i].data, vec[i].stop, 1);
      idle(2 * BIT);
      chk("vec_valid", 32'(rx_valid), 32'(vec[i].stop));
      if (vec[i].stop) chk("vec_data", 32'(rx_data), 32'(vec[i].data));
      chk("vec_level", 32'(level), 32'(vec[i].stop));
      chk("vec_ferr_pulses", ferr_pulses - p0, 32'(!vec[i].stop));
      chk("vec_ferr_cycles", ferr_hi - h0, 32'(!vec[i].stop));
      pop_one();
      chk("vec_pop_level", 32'(level), 0);
      chk("vec_pop_valid", 32'(rx_valid), 0);
    end

    rx_ready = 1'b1;
    p0 = npop;
    h0 = ferr_pulses;
    send(8'hA5, 1'b1, 1);
    idle(BIT);
    chk("rdy_npop", npop - p0, 1);
    chk("rdy_byte", 32'(last_pop), 32'hA5);
    chk("rdy_level", 32'(level), 0);
    chk("rdy_ferr", ferr_pulses - h0, 0);
    rx_ready = 1'b0;

    p0 = ferr_pulses;
    rxd = 1'b0;
    idle(3 * DIV);
    rxd = 1'b1;
    idle(2 * BIT);
    chk("glitch_level", 32'(level), 0);
    chk("glitch_ferr", ferr_pulses - p0, 0);
    send(8'h96, 1'b1, 1);
    idle(BIT);
    chk("glitch_next_data", 32'(rx_data), 32'h96);
    chk("glitch_next_level", 32'(level), 1);
    pop_one();

    p0 = ferr_pulses;
    h0 = ferr_hi;
    send(8'h3C, 1'b0, 3);
    idle(2 * BIT);
    chk("brk_ferr_pulses", ferr_pulses - p0, 1);
    chk("brk_ferr_cycles", ferr_hi - h0, 1);
    chk("brk_level", 32'(level), 0);
    send(8'h5A, 1'b1, 1);
    idle(BIT);
    chk("brk_next_data", 32'(rx_data), 32'h5A);
    chk("brk_next_level", 32'(level), 1);
    pop_one();

    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 1);
    idle(BIT);
    chk("ovr_level", 32'(level), 16);
    chk("ovr_flag", 32'(overrun), 1);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovr_drain_valid", 32'(rx_valid), 1);
      chk("ovr_drain_data", 32'(rx_data), i);
      @(negedge clk);
    end
    rx_ready = 1'b0;
    chk("ovr_empty_valid", 32'(rx_valid), 0);
    chk("ovr_empty_level", 32'(level), 0);
    chk("ovr_sticky", 32'(overrun), 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 0);

    // Measure start-edge-to-rx_valid latency, then replay it phase-aligned to pop on the push edge
    c0 = cyc;
    lat = 0;
    fork
      send(8'h77, 1'b1, 1);
      begin
        t = 0;
        while (!rx_valid && t < 2000) begin
          @(negedge clk);
          t++;
        end
        lat = cyc - c0;
      end
    join
    chk("lat_window", 32'((lat >= 606 && lat <= 613) ? 1 : 0), 1);
    chk("lat_data", 32'(rx_data), 32'h77);
    pop_one();
    while ((cyc - c0) % DIV != 0) @(negedge clk);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1);
    c1 = cyc;
    fork
      send(8'h10, 1'b1, 1);
      begin
        while (cyc < c1 + lat - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(4);
    chk("coinc_ovr", 32'(overrun), 0);
    chk("coinc_level", 32'(level), 16);
    rx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("coinc_drain_data", 32'(rx_data), i);
      @(negedge clk);
    end
    rx_ready = 1'b0;
    chk("coinc_empty", 32'(rx_valid), 0);

    send(8'hE7, 1'b1, 1);
    idle(BIT);
    chk("prerst_level", 32'(level), 1);
    b = 8'h5F;
    rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(BIT);
    end
    rxd = b[4];
    idle(BIT / 2);
    p0 = ferr_pulses;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rx_valid), 0);
    chk("midrst_data", 32'(rx_data), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_ferr", 32'(frame_err), 0);
    chk("midrst_ovr", 32'(overrun), 0);
    rxd = 1'b0;
    idle(4);
    reset_n = 1'b1;
    idle(3 * DIV);
    rxd = 1'b1;
    idle(2 * BIT);
    chk("rel_low_level", 32'(level), 0);
    send(8'hC3, 1'b1, 1);
    idle(BIT);
    chk("postrst_data", 32'(rx_data), 32'hC3);
    chk("postrst_level", 32'(level), 1);
    chk("postrst_ferr", ferr_pulses - p0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
